dcm_prog_ctrl: RTL and testbench
================================

DCM_PROG_CTRL -- requirements
Module: dcm_prog_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1024, meaning the number of clk cycles to wait for DCM confirmation before flagging an error.
REQ-002 The block SHALL have parameter DEFAULT_PROG, default 3'd0, meaning the prog value assumed and driven after reset.
REQ-003 clk  input  1  system clock, 100 MHz; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 host_req  input  1  single-cycle request to load host_prog.
REQ-006 host_prog  input  3  target prog value for a host request.
REQ-007 step_up  input  1  single-cycle request for prog+1 (slower clk_2).
REQ-008 step_dn  input  1  single-cycle request for prog-1 (faster clk_2).
REQ-009 dcm_update  output  1  single-cycle update strobe to the divider.
REQ-010 dcm_prog  output  3  prog value presented to the divider; stable whenever dcm_update is high.
REQ-011 dcm_prog_out  input  3  prog value the divider reports as active.
REQ-012 cur_prog  output  3  last confirmed prog value.
REQ-013 busy  output  1  high while a transaction is in ISSUE or WAIT.
REQ-014 done  output  1  single-cycle pulse when a transaction completes successfully.
REQ-015 err  output  1  single-cycle pulse on timeout.
REQ-016 sat  output  1  single-cycle pulse when a step request is dropped at a boundary.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-018 Pending flags: host_req SHALL set host_pend and latch host_prog; step_up or step_dn SHALL set step_pend with direction; flags SHALL be latched in any state, and a newer request of the same class SHALL overwrite the older one.
REQ-019 If step_up and step_dn are high in the same cycle, both SHALL be ignored.
REQ-020 In IDLE with both flags pending, grant SHALL alternate round-robin (host first after reset); with one flag pending, that flag SHALL be granted; the granted flag SHALL be cleared in the grant cycle.
REQ-021 Step target SHALL be cur_prog±1; up at 7 or down at 0 SHALL produce a sat pulse the cycle after grant, with no update, and the FSM SHALL stay in IDLE.
REQ-022 If the target equals cur_prog, done SHALL pulse the cycle after grant, with no dcm_update, and the FSM SHALL stay in IDLE.
REQ-023 Otherwise, grant in cycle N: dcm_prog SHALL be set to the target and the FSM SHALL go to ISSUE; dcm_update SHALL be high for exactly cycle N+1; WAIT SHALL be entered at N+2.
REQ-024 WAIT: when dcm_prog_out equals the target, cur_prog SHALL be updated, done SHALL pulse on the next cycle, and the FSM SHALL return to IDLE.
REQ-025 WAIT: after TIMEOUT cycles without a match, err SHALL pulse, cur_prog SHALL be unchanged, dcm_prog SHALL be restored to cur_prog, and the FSM SHALL return to IDLE; the timeout counter SHALL be cleared on WAIT entry.
REQ-026 busy SHALL be high exactly in ISSUE and WAIT.
REQ-027 At most one of done, err or sat SHALL pulse per cycle.
REQ-028 A new grant SHALL not occur in the same cycle as a done, err or sat pulse.

Reset
REQ-029 While rst is high, the FSM SHALL be in IDLE and all pending flags and counters SHALL be cleared.
REQ-030 While rst is high, outputs SHALL be: dcm_update=0, dcm_prog=DEFAULT_PROG, cur_prog=DEFAULT_PROG, and busy, done, err, sat=0.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately with no done or err pulse.

Verification
REQ-032 Bench SHALL cover: host_req, host_prog=5, divider model echoes after 3 cycles -> dcm_update one cycle with dcm_prog=5, then done, cur_prog=5, busy low.
REQ-033 Bench SHALL cover: cur_prog=7, step_up -> sat pulse, no dcm_update, cur_prog stays 7.
REQ-034 Bench SHALL cover: host_req(2) and step_dn in the same cycle from cur_prog=4 -> host served first (prog 2), then step served (prog 1).
REQ-035 Bench SHALL cover: divider never echoes, TIMEOUT=16 -> err exactly 16 cycles after WAIT entry, cur_prog unchanged, dcm_prog restored.
REQ-036 Bench SHALL cover: step_up and step_dn in the same cycle -> no transaction, no pulses.
REQ-037 Bench SHALL cover: rst asserted during WAIT -> busy=0, cur_prog=0, no done or err.

Source files
------------

// File: rtl/dcm_prog_ctrl_if.sv
// Host/divider-side signal bundle for dcm_prog_ctrl.
// All requests and result pulses are single-cycle strobes sampled on the rising clk edge.
// There is no ready back-pressure: requests arriving during a transaction are held as pending flags.
interface dcm_prog_ctrl_if;
    logic       host_req;
    logic [2:0] host_prog;
    logic       step_up;
    logic       step_dn;
    logic       dcm_update;
    logic [2:0] dcm_prog;
    logic [2:0] dcm_prog_out;
    logic [2:0] cur_prog;
    logic       busy;
    logic       done;
    logic       err;
    logic       sat;

    modport master (
        output host_req, host_prog, step_up, step_dn, dcm_prog_out,
        input  dcm_update, dcm_prog, cur_prog, busy, done, err, sat
    );

    modport slave (
        input  host_req, host_prog, step_up, step_dn, dcm_prog_out,
        output dcm_update, dcm_prog, cur_prog, busy, done, err, sat
    );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// Arbitrates host loads and +/-1 steps of a DCM divider prog value, issues the update
// strobe and waits (with timeout) for the divider to confirm the new value.
module dcm_prog_ctrl #(
    parameter int         TIMEOUT      = 1024,
    parameter logic [2:0] DEFAULT_PROG = 3'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    dcm_prog_ctrl_if.slave        bus_io,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          host_pend_q, host_pend_d;
    logic [2:0]    host_prog_q, host_prog_d;
    logic          step_pend_q, step_pend_d;
    logic          step_dir_q, step_dir_d;
    logic          rr_q, rr_d;
    logic [2:0]    target_q, target_d;
    logic [2:0]    dcm_prog_q, dcm_prog_d;
    logic [2:0]    cur_prog_q, cur_prog_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sat_q, sat_d;

    logic          grant_host;
    logic          grant_step;
    logic          grant_sat;
    logic [2:0]    grant_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            host_pend_q <= 1'b0;
            host_prog_q <= 3'd0;
            step_pend_q <= 1'b0;
            step_dir_q  <= 1'b0;
            rr_q        <= 1'b0;
            target_q    <= DEFAULT_PROG;
            dcm_prog_q  <= DEFAULT_PROG;
            cur_prog_q  <= DEFAULT_PROG;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            host_pend_q <= host_pend_d;
            host_prog_q <= host_prog_d;
            step_pend_q <= step_pend_d;
            step_dir_q  <= step_dir_d;
            rr_q        <= rr_d;
            target_q    <= target_d;
            dcm_prog_q  <= dcm_prog_d;
            cur_prog_q  <= cur_prog_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sat_q       <= sat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        host_pend_d = host_pend_q;
        host_prog_d = host_prog_q;
        step_pend_d = step_pend_q;
        step_dir_d  = step_dir_q;
        rr_d        = rr_q;
        target_d    = target_q;
        dcm_prog_d  = dcm_prog_q;
        cur_prog_d  = cur_prog_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sat_d       = 1'b0;
        grant_host  = 1'b0;
        grant_step  = 1'b0;
        grant_sat   = 1'b0;
        grant_tgt   = cur_prog_q;

        // No grant while a result pulse is out, so pulses never overlap a new grant.
        if (state_q == IDLE && !(done_q || err_q || sat_q)) begin
            if (host_pend_q && (!step_pend_q || !rr_q)) begin
                grant_host = 1'b1;
            end else if (step_pend_q) begin
                grant_step = 1'b1;
            end
        end

        // The round-robin pointer only moves on contention; rr_q=1 favours the step.
        if (host_pend_q && step_pend_q && (grant_host || grant_step)) begin
            rr_d = grant_host;
        end

        if (grant_host) begin
            grant_tgt = host_prog_q;
        end else if (grant_step) begin
            grant_sat = step_dir_q ? (cur_prog_q == 3'd7) : (cur_prog_q == 3'd0);
            grant_tgt = step_dir_q ? (cur_prog_q + 3'd1) : (cur_prog_q - 3'd1);
        end

        // A request arriving in the grant cycle wins over the clear.
        host_pend_d = bus_io.host_req | (host_pend_q & ~grant_host);
        if (bus_io.host_req) begin
            host_prog_d = bus_io.host_prog;
        end
        if (bus_io.step_up ^ bus_io.step_dn) begin
            step_pend_d = 1'b1;
            step_dir_d  = bus_io.step_up;
        end else if (grant_step) begin
            step_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (grant_host || grant_step) begin
                    if (grant_sat) begin
                        sat_d = 1'b1;
                    end else if (grant_tgt == cur_prog_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d   = grant_tgt;
                        dcm_prog_d = grant_tgt;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus_io.dcm_prog_out == target_q) begin
                    cur_prog_d = target_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d      = 1'b1;
                    dcm_prog_d = cur_prog_q;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_io.dcm_update = (state_q == ISSUE);
        bus_io.busy       = (state_q != IDLE);
        bus_io.dcm_prog   = dcm_prog_q;
        bus_io.cur_prog   = cur_prog_q;
        bus_io.done       = done_q;
        bus_io.err        = err_q;
        bus_io.sat        = sat_q;
        state_o           = state_q;
    end

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl with a divider model that echoes dcm_prog three
// cycles after an update strobe when echo_en is set.
module tb_dcm_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    bit         echo_en = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    dcm_prog_ctrl_if bus ();

    dcm_prog_ctrl #(.TIMEOUT(16), .DEFAULT_PROG(3'd0)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_io  (bus),
        .state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- divider model ----------------
    logic [2:0] echo_val;
    int         echo_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dcm_prog_out <= 3'd0;
            echo_val         <= 3'd0;
            echo_cnt         <= 0;
        end else if (bus.dcm_update && echo_en) begin
            echo_val <= bus.dcm_prog;
            echo_cnt <= 3;
        end else if (echo_cnt != 0) begin
            echo_cnt <= echo_cnt - 1;
            if (echo_cnt == 1) bus.dcm_prog_out <= echo_val;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_host(input logic [2:0] v);
        @(negedge clk);
        bus.host_req  = 1'b1;
        bus.host_prog = v;
        @(negedge clk);
        bus.host_req  = 1'b0;
    endtask

    task automatic pulse_step(input logic up, input logic dn);
        @(negedge clk);
        bus.step_up = up;
        bus.step_dn = dn;
        @(negedge clk);
        bus.step_up = 1'b0;
        bus.step_dn = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_update(output bit seen, output logic [2:0] p);
        seen = 1'b0;
        p    = 3'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.dcm_update) begin
                seen = 1'b1;
                p    = bus.dcm_prog;
                break;
            end
        end
    endtask

    task automatic set_cur(input logic [2:0] v);
        bit seen;
        echo_en = 1'b1;
        pulse_host(v);
        wait_done(seen);
        n_cmp++;
        if (!seen || bus.cur_prog !== v) begin
            n_bad++;
            $display("FAIL set_cur: done=%0b cur_prog=%0d want done=1 cur_prog=%0d", seen, bus.cur_prog, v);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.dcm_update, bus.busy, bus.done, bus.err, bus.sat} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: upd/busy/done/err/sat=%b want 00000",
                     {bus.dcm_update, bus.busy, bus.done, bus.err, bus.sat});
        end
        n_cmp++;
        if (bus.dcm_prog !== 3'd0 || bus.cur_prog !== 3'd0 || dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_values: dcm_prog=%0d cur_prog=%0d state=%0d want 0 0 0",
                     bus.dcm_prog, bus.cur_prog, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_host_load();
        int done_at = 0;
        int extra_upd = 0;
        echo_en = 1'b1;
        pulse_host(3'd5);
        @(negedge clk);
        n_cmp++;
        if (bus.dcm_update !== 1'b1 || bus.dcm_prog !== 3'd5 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL host_issue: upd=%b dcm_prog=%0d busy=%b want 1 5 1",
                     bus.dcm_update, bus.dcm_prog, bus.busy);
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.dcm_update) extra_upd++;
            if (bus.done) begin
                done_at = i;
                break;
            end
        end
        n_cmp++;
        if (done_at !== 5 || extra_upd !== 0) begin
            n_bad++;
            $display("FAIL host_done_timing: done_at=%0d extra_upd=%0d want 5 0", done_at, extra_upd);
        end
        n_cmp++;
        if (bus.cur_prog !== 3'd5 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL host_result: cur_prog=%0d busy=%b want 5 0", bus.cur_prog, bus.busy);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL host_done_width: done=%b want 0", bus.done);
        end
    endtask

    task automatic test_noop();
        pulse_host(3'd5);
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.dcm_update !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL noop: done=%b upd=%b busy=%b want 1 0 0", bus.done, bus.dcm_update, bus.busy);
        end
    endtask

    task automatic test_sat_up();
        set_cur(3'd7);
        pulse_step(1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (bus.sat !== 1'b1 || bus.dcm_update !== 1'b0 || bus.busy !== 1'b0 || bus.cur_prog !== 3'd7) begin
            n_bad++;
            $display("FAIL sat_up: sat=%b upd=%b busy=%b cur=%0d want 1 0 0 7",
                     bus.sat, bus.dcm_update, bus.busy, bus.cur_prog);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.sat !== 1'b0 || bus.done !== 1'b0 || bus.dcm_update !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_up_after: sat=%b done=%b upd=%b want 0 0 0", bus.sat, bus.done, bus.dcm_update);
        end
    endtask

    task automatic test_host_and_step();
        bit         seen;
        logic [2:0] p;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_cur(3'd4);
        @(negedge clk);
        bus.host_req  = 1'b1;
        bus.host_prog = 3'd2;
        bus.step_dn   = 1'b1;
        @(negedge clk);
        bus.host_req  = 1'b0;
        bus.step_dn   = 1'b0;
        wait_update(seen, p);
        n_cmp++;
        if (!seen || p !== 3'd2) begin
            n_bad++;
            $display("FAIL rr_first: seen=%0b dcm_prog=%0d want 1 2", seen, p);
        end
        wait_done(seen);
        n_cmp++;
        if (!seen || bus.cur_prog !== 3'd2) begin
            n_bad++;
            $display("FAIL rr_first_done: seen=%0b cur=%0d want 1 2", seen, bus.cur_prog);
        end
        wait_update(seen, p);
        n_cmp++;
        if (!seen || p !== 3'd1) begin
            n_bad++;
            $display("FAIL rr_second: seen=%0b dcm_prog=%0d want 1 1", seen, p);
        end
        wait_done(seen);
        n_cmp++;
        if (!seen || bus.cur_prog !== 3'd1) begin
            n_bad++;
            $display("FAIL rr_second_done: seen=%0b cur=%0d want 1 1", seen, bus.cur_prog);
        end
    endtask

    task automatic test_timeout();
        int err_at = 0;
        bit got_done = 1'b0;
        echo_en = 1'b0;
        pulse_host(3'd6);
        @(negedge clk);
        n_cmp++;
        if (bus.dcm_update !== 1'b1 || bus.dcm_prog !== 3'd6) begin
            n_bad++;
            $display("FAIL to_issue: upd=%b dcm_prog=%0d want 1 6", bus.dcm_update, bus.dcm_prog);
        end
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== 2'd2 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL to_wait_entry: state=%0d busy=%b want 2 1", dbg_state, bus.busy);
        end
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (bus.done) got_done = 1'b1;
            if (bus.err) begin
                err_at = i;
                break;
            end
        end
        n_cmp++;
        if (err_at !== 16 || got_done) begin
            n_bad++;
            $display("FAIL to_err_timing: err_at=%0d done_seen=%0b want 16 0", err_at, got_done);
        end
        n_cmp++;
        if (bus.cur_prog !== 3'd1 || bus.dcm_prog !== 3'd1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL to_restore: cur=%0d dcm_prog=%0d busy=%b want 1 1 0",
                     bus.cur_prog, bus.dcm_prog, bus.busy);
        end
    endtask

    task automatic test_step_both();
        int activity = 0;
        echo_en = 1'b1;
        pulse_step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.dcm_update || bus.busy || bus.done || bus.err || bus.sat) activity++;
        end
        n_cmp++;
        if (activity !== 0 || bus.cur_prog !== 3'd1) begin
            n_bad++;
            $display("FAIL step_both: active_cycles=%0d cur=%0d want 0 1", activity, bus.cur_prog);
        end
    endtask

    task automatic test_reset_in_wait();
        int pulses = 0;
        echo_en = 1'b0;
        pulse_host(3'd3);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== 2'd2) begin
            n_bad++;
            $display("FAIL rst_wait_entry: state=%0d want 2", dbg_state);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.cur_prog !== 3'd0 || bus.dcm_prog !== 3'd0 || dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_abort: busy=%b cur=%0d dcm_prog=%0d state=%0d want 0 0 0 0",
                     bus.busy, bus.cur_prog, bus.dcm_prog, dbg_state);
        end
        @(negedge clk);
        if (bus.done || bus.err) pulses++;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL rst_no_pulse: pulse_or_busy_cycles=%0d want 0", pulses);
        end
    endtask

    task automatic test_sat_dn();
        pulse_step(1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (bus.sat !== 1'b1 || bus.dcm_update !== 1'b0 || bus.cur_prog !== 3'd0) begin
            n_bad++;
            $display("FAIL sat_dn: sat=%b upd=%b cur=%0d want 1 0 0", bus.sat, bus.dcm_update, bus.cur_prog);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        bus.host_req  = 1'b0;
        bus.host_prog = 3'd0;
        bus.step_up   = 1'b0;
        bus.step_dn   = 1'b0;
        test_reset();
        test_host_load();
        test_noop();
        test_sat_up();
        test_host_and_step();
        test_timeout();
        test_step_both();
        test_reset_in_wait();
        test_sat_dn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
